// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time over valid/ready and services it
// from a little-endian 64-bit word store after a fixed LATENCY, flagging misaligned/out-of-range accesses.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error
);
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [63:0] DEPTH_BYTES = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  COUNT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_next;
    logic [3:0]       count;
    logic [63:0]      addr_q, wdata_q;
    logic [1:0]       size_q;
    logic             write_q, unsigned_q;
    logic [63:0]      mem [DEPTH_WORDS];

    logic             commit;
    logic [63:0]      c_addr, c_wdata;
    logic [1:0]       c_size;
    logic             c_write, c_unsigned, c_error;
    logic [2:0]       offset;
    logic [IDX_W-1:0] index;
    logic [63:0]      word_rd, word_shift, load_data, wdata_shift, word_wr;
    logic [7:0]       size_mask, byte_en;

    assign req_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY=1 the commit happens on the accepting edge, so it must see the live request.
    always_comb begin
        if (state == IDLE) begin
            c_addr     = req_addr;
            c_wdata    = req_wdata;
            c_size     = req_size;
            c_write    = req_write;
            c_unsigned = req_unsigned;
        end else begin
            c_addr     = addr_q;
            c_wdata    = wdata_q;
            c_size     = size_q;
            c_write    = write_q;
            c_unsigned = unsigned_q;
        end
    end

    always_comb begin
        offset      = c_addr[2:0];
        index       = c_addr[IDX_W+2:3];
        word_rd     = mem[index];
        c_error     = ((c_addr & ((64'd1 << c_size) - 64'd1)) != 64'd0) || (c_addr >= DEPTH_BYTES);
        word_shift  = word_rd >> {offset, 3'b000};
        unique case (c_size)
            2'd0:    load_data = c_unsigned ? {56'd0, word_shift[7:0]}
                                            : {{56{word_shift[7]}}, word_shift[7:0]};
            2'd1:    load_data = c_unsigned ? {48'd0, word_shift[15:0]}
                                            : {{48{word_shift[15]}}, word_shift[15:0]};
            2'd2:    load_data = c_unsigned ? {32'd0, word_shift[31:0]}
                                            : {{32{word_shift[31]}}, word_shift[31:0]};
            default: load_data = word_shift;
        endcase
        unique case (c_size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        byte_en     = size_mask << offset;
        wdata_shift = c_wdata << {offset, 3'b000};
        word_wr     = word_rd;
        for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) word_wr[i*8 +: 8] = wdata_shift[i*8 +: 8];
        end
    end

    // Storage is deliberately not reset; reset only suppresses a commit on the same edge.
    always_ff @(posedge clock) begin
        if (!reset && commit && c_write && !c_error) mem[index] <= word_wr;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= 4'd0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            size_q     <= 2'd0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_error <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                count      <= COUNT_INIT;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (commit) begin
                resp_valid <= 1'b1;
                resp_error <= c_error;
                resp_rdata <= (c_write || c_error) ? 64'd0 : load_data;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= 64'd0;
                resp_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances (LATENCY 2, 1, 3) driven by
// directed steps and random traffic, compared against a byte-array reference model.
module tb_data_mem_responder;
    logic        clock;
    logic        reset        [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_write    [3];
    logic [63:0] req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [63:0] req_wdata    [3];
    logic        resp_valid   [3];
    logic        resp_ready   [3];
    logic [63:0] resp_rdata   [3];
    logic        resp_error   [3];

    int          lat_tab [3] = '{2, 1, 3};
    logic [7:0]  model_mem [3][2048];
    int          checks = 0;
    int          fails  = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
        .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut2 (
        .clock(clock), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
        .req_unsigned(req_unsigned[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
        .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: bytes in a flat array, result assembled arithmetically.
    function automatic void model_access(input int inst, input bit wr, input logic [63:0] addr,
                                         input logic [1:0] size, input bit uns,
                                         input logic [63:0] wdata,
                                         output logic [63:0] rdata, output logic err);
        int n = 1 << size;
        err   = ((addr % 64'(n)) != 0) || (addr >= 64'd2048);
        rdata = 64'd0;
        if (err) return;
        for (int i = 0; i < n; i++) begin
            if (wr) model_mem[inst][int'(addr) + i] = wdata[8*i +: 8];
            else    rdata = rdata | (64'(model_mem[inst][int'(addr) + i]) << (8*i));
        end
        if (!wr && !uns && n < 8 && rdata[8*n-1]) rdata = rdata | (~64'd0 << (8*n));
    endfunction

    task automatic drive_req(input int inst, input bit wr, input logic [63:0] addr,
                             input logic [1:0] size, input bit uns, input logic [63:0] wdata);
        req_valid[inst]    = 1'b1;
        req_write[inst]    = wr;
        req_addr[inst]     = addr;
        req_size[inst]     = size;
        req_unsigned[inst] = uns;
        req_wdata[inst]    = wdata;
    endtask

    task automatic applyStimulus(input int inst, input bit wr, input logic [63:0] addr,
                                 input logic [1:0] size, input bit uns, input logic [63:0] wdata,
                                 input int hold, output logic [63:0] obs_d, output logic obs_e);
        logic [63:0] exp_d;
        logic        exp_e;
        int          k;
        @(negedge clock);
        drive_req(inst, wr, addr, size, uns, wdata);
        checkOutput("req_ready before accept", 64'(req_ready[inst]), 64'd1);
        @(posedge clock); #1;
        req_valid[inst] = 1'b0;
        model_access(inst, wr, addr, size, uns, wdata, exp_d, exp_e);
        k = 0;
        while (!resp_valid[inst] && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        checkOutput("resp latency edges", 64'(k), 64'(lat_tab[inst] - 1));
        checkOutput("resp_rdata", resp_rdata[inst], exp_d);
        checkOutput("resp_error", 64'(resp_error[inst]), 64'(exp_e));
        obs_d = resp_rdata[inst];
        obs_e = resp_error[inst];
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            drive_req(inst, 1'b1, 64'h10, 2'd3, 1'b0, 64'h0);
            @(posedge clock); #1;
            checkOutput("hold resp_valid", 64'(resp_valid[inst]), 64'd1);
            checkOutput("hold resp_rdata", resp_rdata[inst], exp_d);
            checkOutput("hold req_ready", 64'(req_ready[inst]), 64'd0);
        end
        @(negedge clock);
        req_valid[inst]  = 1'b0;
        resp_ready[inst] = 1'b1;
        @(posedge clock); #1;
        resp_ready[inst] = 1'b0;
        checkOutput("consume resp_valid", 64'(resp_valid[inst]), 64'd0);
        checkOutput("consume req_ready", 64'(req_ready[inst]), 64'd1);
        checkOutput("consume resp_rdata", resp_rdata[inst], 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic        e;
        logic        rr;
        int          accepts;
        int          k;
        logic [63:0] exp_d;
        logic        exp_e;

        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 64'd0;
            req_size[i] = 2'd0; req_unsigned[i] = 1'b0; req_wdata[i] = 64'd0; resp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset req_ready", 64'(req_ready[i]), 64'd1);
            checkOutput("reset resp_valid", 64'(resp_valid[i]), 64'd0);
            checkOutput("reset resp_rdata", resp_rdata[i], 64'd0);
            checkOutput("reset resp_error", 64'(resp_error[i]), 64'd0);
        end
        @(negedge clock);
        for (int i = 0; i < 3; i++) reset[i] = 1'b0;

        // Fill the low 32 words so random loads only touch defined bytes.
        for (int w = 0; w < 32; w++)
            applyStimulus(0, 1'b1, 64'(w * 8), 2'd3, 1'b0, {$urandom, $urandom}, 0, d, e);

        applyStimulus(0, 1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, 0, d, e);
        applyStimulus(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 0, d, e);
        checkOutput("dir load double", d, 64'h1122334455667788);
        applyStimulus(0, 1'b1, 64'h13, 2'd0, 1'b0, 64'hAB, 0, d, e);
        applyStimulus(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 0, d, e);
        checkOutput("dir merged double", d, 64'h11223344AB667788);
        applyStimulus(0, 1'b0, 64'h13, 2'd0, 1'b0, 64'h0, 0, d, e);
        checkOutput("dir signed byte", d, 64'hFFFFFFFFFFFFFFAB);
        applyStimulus(0, 1'b0, 64'h13, 2'd0, 1'b1, 64'h0, 0, d, e);
        checkOutput("dir unsigned byte", d, 64'h00000000000000AB);
        applyStimulus(0, 1'b0, 64'h11, 2'd1, 1'b0, 64'h0, 0, d, e);
        checkOutput("dir misaligned error", 64'(e), 64'd1);
        checkOutput("dir misaligned rdata", d, 64'd0);
        applyStimulus(0, 1'b1, 64'h14, 2'd2, 1'b0, 64'hDEADBEEF, 0, d, e);
        applyStimulus(0, 1'b1, 64'h800, 2'd2, 1'b0, 64'hCAFEBABE, 0, d, e);
        checkOutput("dir range error", 64'(e), 64'd1);
        applyStimulus(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 5, d, e);
        checkOutput("dir hold readback", d, 64'hDEADBEEFAB667788);
        applyStimulus(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 0, d, e);
        checkOutput("dir no ghost store", d, 64'hDEADBEEFAB667788);

        for (int n = 0; n < 60; n++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 7) == 0) ? 64'(2048 + $urandom_range(0, 255))
                                            : 64'($urandom_range(0, 255));
            applyStimulus(0, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), {$urandom, $urandom}, 0, d, e);
        end

        // LATENCY=1: back-to-back loads with resp_ready tied high.
        applyStimulus(1, 1'b1, 64'h40, 2'd3, 1'b0, 64'h0123456789ABCDEF, 0, d, e);
        @(negedge clock);
        drive_req(1, 1'b0, 64'h40, 2'd3, 1'b0, 64'h0);
        resp_ready[1] = 1'b1;
        accepts = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            rr = req_ready[1];
            @(posedge clock); #1;
            checkOutput("tput resp_valid", 64'(resp_valid[1]), 64'(rr));
            if (rr) checkOutput("tput rdata", resp_rdata[1], 64'h0123456789ABCDEF);
            accepts += int'(rr);
        end
        checkOutput("tput accepts in 8 cycles", 64'(accepts), 64'd4);
        @(negedge clock);
        req_valid[1]  = 1'b0;
        resp_ready[1] = 1'b0;

        // LATENCY=3: reset one cycle after accepting a store drops it.
        applyStimulus(2, 1'b1, 64'h20, 2'd3, 1'b0, 64'hCAFEF00D12345678, 0, d, e);
        @(negedge clock);
        drive_req(2, 1'b1, 64'h20, 2'd3, 1'b0, 64'h5555AAAA5555AAAA);
        @(posedge clock); #1;
        req_valid[2] = 1'b0;
        checkOutput("accepted req_ready", 64'(req_ready[2]), 64'd0);
        @(negedge clock);
        reset[2] = 1'b1;
        @(posedge clock); #1;
        checkOutput("wait reset req_ready", 64'(req_ready[2]), 64'd1);
        checkOutput("wait reset resp_valid", 64'(resp_valid[2]), 64'd0);
        checkOutput("wait reset resp_rdata", resp_rdata[2], 64'd0);
        @(negedge clock);
        reset[2] = 1'b0;
        applyStimulus(2, 1'b0, 64'h20, 2'd3, 1'b0, 64'h0, 0, d, e);
        checkOutput("dropped store readback", d, 64'hCAFEF00D12345678);

        // Reset while in RESP keeps the committed store.
        @(negedge clock);
        drive_req(2, 1'b1, 64'h28, 2'd2, 1'b0, 64'h00000000FEEDFACE);
        @(posedge clock); #1;
        req_valid[2] = 1'b0;
        model_access(2, 1'b1, 64'h28, 2'd2, 1'b0, 64'h00000000FEEDFACE, exp_d, exp_e);
        k = 0;
        while (!resp_valid[2] && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        checkOutput("resp-reset latency edges", 64'(k), 64'd2);
        @(negedge clock);
        reset[2] = 1'b1;
        @(posedge clock); #1;
        checkOutput("resp reset resp_valid", 64'(resp_valid[2]), 64'd0);
        checkOutput("resp reset resp_error", 64'(resp_error[2]), 64'd0);
        @(negedge clock);
        reset[2] = 1'b0;
        applyStimulus(2, 1'b0, 64'h28, 2'd2, 1'b1, 64'h0, 0, d, e);
        checkOutput("committed store readback", d, 64'h00000000FEEDFACE);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
